// File: rtl/rf_write_arbiter_if.sv
// Bus bundle for rf_write_arbiter: WB and aux write requests, decode hazard query
// and the register-file write port. Arbiter side uses the slave modport.
interface rf_write_arbiter_if;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    // aux handshake: a write transfers on any clock edge where aux_valid && aux_ready;
    // the source holds aux_rd/aux_wd stable while aux_valid is high and not yet accepted.
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_rd;
    logic [31:0] aux_wd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        wb_stall;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;

    modport master (
        output wb_we, wb_rd, wb_wd, aux_valid, aux_rd, aux_wd, rs1, rs2,
        input  aux_ready, busy_rs1, busy_rs2, wb_stall, rf_we, rf_a3, rf_wd
    );

    modport slave (
        input  wb_we, wb_rd, wb_wd, aux_valid, aux_rd, aux_wd, rs1, rs2,
        output aux_ready, busy_rs1, busy_rs2, wb_stall, rf_we, rf_a3, rf_wd
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB has priority, aux writes queue in a small FIFO.
// Define RF_ARB_STATS_EN to add the saturating conflict_cnt output.
module rf_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef RF_ARB_STATS_EN
    output logic [15:0]       conflict_cnt,
`endif
    rf_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic          live_q [DEPTH];
    logic [4:0]    rd_q   [DEPTH];
    logic [31:0]   wd_q   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;
    logic          stall_q;
    logic [4:0]    last_a3;
    logic [31:0]   last_wd;

    logic empty;
    logic full;
    logic wb_grant;
    logic pop;
    logic push;
    logic conflict;
    logic busy1;
    logic busy2;

    assign empty         = (count == '0);
    assign full          = (count == CW'(DEPTH));
    assign bus.aux_ready = rst_n && !full;
    assign bus.wb_stall  = stall_q;

    always_comb begin
        wb_grant   = rst_n && !stall_q && bus.wb_we && (bus.wb_rd != 5'd0);
        pop        = !empty && (stall_q || !wb_grant);
        push       = bus.aux_valid && bus.aux_ready && (bus.aux_rd != 5'd0);
        conflict   = !empty && wb_grant;
        starve_nxt = conflict ? starve_cnt + 1'b1 : '0;

        // Killed entries have live cleared, so only live entries create hazards.
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (rd_q[i] == bus.rs1)) busy1 = 1'b1;
            if (live_q[i] && (rd_q[i] == bus.rs2)) busy2 = 1'b1;
        end
        bus.busy_rs1 = busy1 && (bus.rs1 != 5'd0);
        bus.busy_rs2 = busy2 && (bus.rs2 != 5'd0);

        if (wb_grant) begin
            bus.rf_we = 1'b1;
            bus.rf_a3 = bus.wb_rd;
            bus.rf_wd = bus.wb_wd;
        end else if (pop) begin
            bus.rf_we = live_q[rd_ptr];
            bus.rf_a3 = rd_q[rd_ptr];
            bus.rf_wd = wd_q[rd_ptr];
        end else begin
            bus.rf_we = 1'b0;
            bus.rf_a3 = last_a3;
            bus.rf_wd = last_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                live_q[i] <= 1'b0;
                rd_q[i]   <= '0;
                wd_q[i]   <= '0;
            end
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
            last_a3    <= '0;
            last_wd    <= '0;
        end else begin
            if (wb_grant) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rd_q[i] == bus.wb_rd) live_q[i] <= 1'b0;
                end
            end
            if (pop) begin
                live_q[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + 1'b1;
            end
            // Written after the kill loop so a same-cycle enqueue stays live.
            if (push) begin
                live_q[wr_ptr] <= 1'b1;
                rd_q[wr_ptr]   <= bus.aux_rd;
                wd_q[wr_ptr]   <= bus.aux_wd;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wb_grant || pop) begin
                last_a3 <= bus.rf_a3;
                last_wd <= bus.rf_wd;
            end
            if (starve_nxt == SW'(STARVE_LIMIT)) begin
                stall_q    <= 1'b1;
                starve_cnt <= '0;
            end else begin
                stall_q    <= 1'b0;
                starve_cnt <= starve_nxt;
            end
        end
    end

`ifdef RF_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (conflict && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif
endmodule
